smac_core: RTL and testbench

Precision-scalable SIMD multiply-accumulate processing element for the DTPU systolic array. Each cycle it multiplies a 64-bit data word by a 64-bit weight word lane-wise (8×INT8, 4×INT16, 2×INT32 or 1×INT64) and adds a 64-bit addend: either the partial sum from the upstream PE or its own previous result. The two-stage pipeline can be built on DSP slices or on LUT fabric with identical cycle behaviour.

---
 rtl/smac_core.sv | 120 ++++++++++++
 tb/tb_smac_core.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/smac_core.sv
// Precision-scalable SIMD multiply-accumulate PE: lane-wise d*w + addend over
// 8x8, 4x16, 2x32 or 1x64-bit lanes, two-stage pipeline, DSP or fabric build.
module smac_core #(
  parameter string USE_FABRIC = "NO"
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        ce,
  input  logic        sclr,
  input  logic [63:0] data_input,
  input  logic [63:0] weight,
  input  logic [63:0] res_mac_p,
  input  logic [3:0]  select_precision,
  input  logic [1:0]  enable_fp_unit,
  input  logic        active_chain,
  output logic [63:0] res_mac_n
);

  logic [1:0]  prec_next, prec_reg;
  logic [63:0] prod_next, prod_reg;
  logic [63:0] psum_reg;
  logic        chain_next, chain_reg;
  logic [63:0] addend, sum_next;
  logic [63:0] p8, p16, p32, p64;
  logic [63:0] s8, s16, s32, s64;
  logic        fp_tie;

  // FP path is reserved; its control is tied off so the integer path always runs.
  assign fp_tie     = (^enable_fp_unit) & 1'b0;
  assign chain_next = active_chain | fp_tie;
  assign addend     = chain_reg ? psum_reg : res_mac_n;

  always_comb begin
    case (select_precision)
      4'h1:    prec_next = 2'd0;
      4'h2:    prec_next = 2'd1;
      4'h4:    prec_next = 2'd2;
      default: prec_next = 2'd3;
    endcase
  end

  // Both builds compute every lane width; only the mapping attribute differs.
  if (USE_FABRIC == "YES") begin : g_fabric
    (* use_dsp = "no" *) logic [63:0] m8, m16, m32, m64;
    (* use_dsp = "no" *) logic [63:0] a8, a16, a32, a64;
    for (genvar gi = 0; gi < 8; gi++) begin : g_l8
      assign m8[gi*8 +: 8] = data_input[gi*8 +: 8] * weight[gi*8 +: 8];
      assign a8[gi*8 +: 8] = prod_reg[gi*8 +: 8] + addend[gi*8 +: 8];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_l16
      assign m16[gi*16 +: 16] = data_input[gi*16 +: 16] * weight[gi*16 +: 16];
      assign a16[gi*16 +: 16] = prod_reg[gi*16 +: 16] + addend[gi*16 +: 16];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_l32
      assign m32[gi*32 +: 32] = data_input[gi*32 +: 32] * weight[gi*32 +: 32];
      assign a32[gi*32 +: 32] = prod_reg[gi*32 +: 32] + addend[gi*32 +: 32];
    end
    assign m64 = data_input * weight;
    assign a64 = prod_reg + addend;
    assign {p8, p16, p32, p64} = {m8, m16, m32, m64};
    assign {s8, s16, s32, s64} = {a8, a16, a32, a64};
  end else begin : g_dsp
    (* use_dsp = "yes" *) logic [63:0] m8, m16, m32, m64;
    (* use_dsp = "yes" *) logic [63:0] a8, a16, a32, a64;
    for (genvar gi = 0; gi < 8; gi++) begin : g_l8
      assign m8[gi*8 +: 8] = data_input[gi*8 +: 8] * weight[gi*8 +: 8];
      assign a8[gi*8 +: 8] = prod_reg[gi*8 +: 8] + addend[gi*8 +: 8];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_l16
      assign m16[gi*16 +: 16] = data_input[gi*16 +: 16] * weight[gi*16 +: 16];
      assign a16[gi*16 +: 16] = prod_reg[gi*16 +: 16] + addend[gi*16 +: 16];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_l32
      assign m32[gi*32 +: 32] = data_input[gi*32 +: 32] * weight[gi*32 +: 32];
      assign a32[gi*32 +: 32] = prod_reg[gi*32 +: 32] + addend[gi*32 +: 32];
    end
    assign m64 = data_input * weight;
    assign a64 = prod_reg + addend;
    assign {p8, p16, p32, p64} = {m8, m16, m32, m64};
    assign {s8, s16, s32, s64} = {a8, a16, a32, a64};
  end

  always_comb begin
    case (prec_next)
      2'd0:    prod_next = p8;
      2'd1:    prod_next = p16;
      2'd2:    prod_next = p32;
      default: prod_next = p64;
    endcase
    case (prec_reg)
      2'd0:    sum_next = s8;
      2'd1:    sum_next = s16;
      2'd2:    sum_next = s32;
      default: sum_next = s64;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prod_reg  <= '0;
      prec_reg  <= '0;
      chain_reg <= 1'b0;
      psum_reg  <= '0;
      res_mac_n <= '0;
    end else if (sclr) begin
      prod_reg  <= '0;
      prec_reg  <= '0;
      chain_reg <= 1'b0;
      psum_reg  <= '0;
      res_mac_n <= '0;
    end else if (ce) begin
      prod_reg  <= prod_next;
      prec_reg  <= prec_next;
      chain_reg <= chain_next;
      psum_reg  <= res_mac_p;
      res_mac_n <= sum_next;
    end
  end

endmodule

// File: tb/tb_smac_core.sv
// Self-checking bench for smac_core: directed precision/accumulate/reset cases,
// then random traffic compared against a lane-arithmetic reference model.
module tb_smac_core;

  logic        clk = 1'b0;
  logic        aresetn, ce, sclr, active_chain;
  logic [63:0] data_input, weight, res_mac_p;
  logic [3:0]  select_precision;
  logic [1:0]  enable_fp_unit;
  logic [63:0] res_no, res_yes;

  int checks = 0;
  int errors = 0;

  // Reference state: the operand set waiting in stage 1, plus the visible result.
  typedef struct {
    logic [63:0] d, w, p;
    logic [3:0]  prec;
    logic        ch;
  } op_t;
  op_t         m_s1;
  logic [63:0] m_res;

  always #5 clk = ~clk;

  smac_core #(.USE_FABRIC("NO")) u_no (
    .clk(clk), .aresetn(aresetn), .ce(ce), .sclr(sclr),
    .data_input(data_input), .weight(weight), .res_mac_p(res_mac_p),
    .select_precision(select_precision), .enable_fp_unit(enable_fp_unit),
    .active_chain(active_chain), .res_mac_n(res_no));

  smac_core #(.USE_FABRIC("YES")) u_yes (
    .clk(clk), .aresetn(aresetn), .ce(ce), .sclr(sclr),
    .data_input(data_input), .weight(weight), .res_mac_p(res_mac_p),
    .select_precision(select_precision), .enable_fp_unit(enable_fp_unit),
    .active_chain(active_chain), .res_mac_n(res_yes));

  function automatic logic [63:0] mac(input logic [63:0] d, input logic [63:0] w,
                                      input logic [63:0] a, input logic [3:0] prec);
    int          wd;
    logic [63:0] mask, r, dl, wl, al;
    case (prec)
      4'h1:    wd = 8;
      4'h2:    wd = 16;
      4'h4:    wd = 32;
      default: wd = 64;
    endcase
    mask = (wd == 64) ? '1 : ((64'd1 << wd) - 64'd1);
    r = '0;
    for (int i = 0; i < 64 / wd; i++) begin
      dl = (d >> (i * wd)) & mask;
      wl = (w >> (i * wd)) & mask;
      al = (a >> (i * wd)) & mask;
      r  = r | ((((dl * wl) + al) & mask) << (i * wd));
    end
    return r;
  endfunction

  function automatic op_t clear_op();
    op_t o;
    o.d = '0; o.w = '0; o.p = '0; o.prec = '0; o.ch = 1'b0;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge in the model using the inputs present at that edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (!aresetn || sclr) begin
      m_s1  = clear_op();
      m_res = '0;
    end else if (ce) begin
      m_res    = mac(m_s1.d, m_s1.w, m_s1.ch ? m_s1.p : m_res, m_s1.prec);
      m_s1.d    = data_input;
      m_s1.w    = weight;
      m_s1.p    = res_mac_p;
      m_s1.prec = select_precision;
      m_s1.ch   = active_chain;
    end
    #1;
    chk({tag, "_no"}, res_no, m_res);
    chk({tag, "_yes"}, res_yes, m_res);
  endtask

  task automatic set_ops(input logic [63:0] d, input logic [63:0] w, input logic [63:0] p,
                         input logic [3:0] prec, input logic ch);
    data_input = d; weight = w; res_mac_p = p; select_precision = prec; active_chain = ch;
  endtask

  logic [63:0] cafe, ones, exp_acc;
  logic [7:0]  b36, b02;

  initial begin
    cafe = 64'hCAFE_CAFE_CAFE_CAFE;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    m_s1 = clear_op();
    m_res = '0;
    aresetn = 1'b0; ce = 1'b1; sclr = 1'b0; enable_fp_unit = 2'b00;
    set_ops(cafe, ones, 64'd0, 4'h1, 1'b1);
    #1;
    chk("reset_no", res_no, 64'd0);
    chk("reset_yes", res_yes, 64'd0);
    step("in_reset");
    #2 aresetn = 1'b1;

    // INT8 chain: result visible after the second edge.
    step("int8_e1");
    set_ops(cafe, ones, 64'd1, 4'h1, 1'b1);
    step("int8_e2");
    chk("int8_const", res_no, 64'h3602_3602_3602_3602);
    step("int8_p1");
    chk("int8_p1_const", res_no, 64'h3602_3602_3602_3603);

    set_ops(cafe, ones, 64'd0, 4'h2, 1'b1); step("int16_a");
    set_ops(cafe, ones, 64'd0, 4'h4, 1'b1); step("int16_b");
    chk("int16_const", res_no, 64'h3502_3502_3502_3502);
    set_ops(cafe, ones, 64'd0, 4'h8, 1'b1); step("int32_b");
    chk("int32_const", res_no, 64'h3501_3502_3501_3502);
    set_ops(64'h0001_0001_0001_FFFF, 64'h0001_0001_0001_0001, 64'd1, 4'h2, 1'b1);
    step("int64_b");
    chk("int64_const", res_yes, 64'h3501_3501_3501_3502);
    step("iso_b");
    chk("iso_const", res_no, 64'h0001_0001_0001_0000);

    // Async reset mid-stream, no clock edge needed.
    set_ops(cafe, ones, 64'd0, 4'h1, 1'b1);
    step("pre_rst");
    #2 aresetn = 1'b0;
    #1;
    m_s1 = clear_op(); m_res = '0;
    chk("async_rst_no", res_no, 64'd0);
    chk("async_rst_yes", res_yes, 64'd0);
    @(negedge clk) aresetn = 1'b1;

    // Accumulate: sclr then n results of n*product per lane.
    set_ops(cafe, ones, 64'd0, 4'h1, 1'b0);
    sclr = 1'b1;
    step("sclr");
    sclr = 1'b0;
    step("acc_fill");
    chk("acc_fill_zero", res_no, 64'd0);
    for (int n = 1; n <= 5; n++) begin
      step("acc");
      b36 = 8'(n * 8'h36);
      b02 = 8'(n * 8'h02);
      exp_acc = {4{b36, b02}};
      chk("acc_n", res_no, exp_acc);
    end
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("freeze");
      chk("freeze_const", res_yes, exp_acc);
    end
    ce = 1'b1;
    step("resume");
    b36 = 8'(6 * 8'h36);
    b02 = 8'(6 * 8'h02);
    chk("resume_n6", res_no, {4{b36, b02}});

    // Random traffic: precision switches, ce toggling, sclr pulses.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 4))
        0: select_precision = 4'h1;
        1: select_precision = 4'h2;
        2: select_precision = 4'h4;
        3: select_precision = 4'h8;
        default: select_precision = 4'($urandom);
      endcase
      data_input     = {$urandom, $urandom};
      weight         = {$urandom, $urandom};
      res_mac_p      = {$urandom, $urandom};
      active_chain   = 1'($urandom);
      enable_fp_unit = 2'($urandom);
      ce             = ($urandom_range(0, 3) != 0);
      sclr           = ($urandom_range(0, 19) == 0);
      step("rand");
      chk("rand_equiv", res_yes, res_no);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
